// File: rtl/universal_shift_reg.sv
// Universal shift register: DEPTH stages of WIDTH bits with forward/backward shift,
// rotate, parallel load and a saturating count of shifted-in stages.
module universal_shift_reg #(
  parameter  int WIDTH = 1,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   en,
  input  logic [2:0]             mode,
  input  logic [WIDTH-1:0]       sin_f,
  input  logic [WIDTH-1:0]       sin_b,
  input  logic [WIDTH*DEPTH-1:0] pdata_in,
  output logic [WIDTH*DEPTH-1:0] pdata_out,
  output logic [WIDTH-1:0]       sout_f,
  output logic [WIDTH-1:0]       sout_b,
  output logic [CW-1:0]          count,
  output logic                   full
);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_SHF  = 3'b001,
    MODE_SHB  = 3'b010,
    MODE_ROTF = 3'b011,
    MODE_ROTB = 3'b100,
    MODE_LOAD = 3'b101
  } mode_e;

  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [WIDTH-1:0] stage     [DEPTH];
  logic [WIDTH-1:0] stage_nxt [DEPTH];
  logic [CW-1:0]    count_nxt;
  logic [CW-1:0]    count_inc;

  assign count_inc = (count == FULL_COUNT) ? count : count + CW'(1);

  // Next state is built only from pre-edge register values, so there is no
  // fall-through from a serial input to the opposite serial output in one cycle.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    stage_nxt = stage;
    count_nxt = count;
    if (en) begin
      case (mode_e'(mode))
        MODE_SHF, MODE_ROTF: begin
          stage_nxt[0] = (mode_e'(mode) == MODE_SHF) ? sin_f : stage[DEPTH-1];
          for (int i = 1; i < DEPTH; i++) stage_nxt[i] = stage[i-1];
          if (mode_e'(mode) == MODE_SHF) count_nxt = count_inc;
        end
        MODE_SHB, MODE_ROTB: begin
          stage_nxt[DEPTH-1] = (mode_e'(mode) == MODE_SHB) ? sin_b : stage[0];
          for (int i = 0; i < DEPTH - 1; i++) stage_nxt[i] = stage[i+1];
          if (mode_e'(mode) == MODE_SHB) count_nxt = count_inc;
        end
        MODE_LOAD: begin
          for (int i = 0; i < DEPTH; i++) stage_nxt[i] = pdata_in[i*WIDTH +: WIDTH];
          count_nxt = FULL_COUNT;
        end
        default: ;  // hold and the reserved encodings 110/111
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (clear) begin
      // NOTE: the stage array is a register bank, not a RAM, so each entry is reset.
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
      count <= '0;
    end else begin
      stage <= stage_nxt;
      count <= count_nxt;
    end
  end

  always_comb begin
    pdata_out = '0;
    for (int i = 0; i < DEPTH; i++) pdata_out[i*WIDTH +: WIDTH] = stage[i];
  end

  assign sout_f = stage[DEPTH-1];
  assign sout_b = stage[0];
  assign full   = (count == FULL_COUNT);

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed self-checking bench for universal_shift_reg: a WIDTH=4/DEPTH=4 instance
// and a WIDTH=4/DEPTH=1 instance, with hand-computed expected values.
module tb_universal_shift_reg;

  localparam logic [2:0] HOLD = 3'b000, SHF = 3'b001, SHB = 3'b010,
                         ROTF = 3'b011, ROTB = 3'b100, LOAD = 3'b101;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // DEPTH=4 instance signals
  logic        a_clear, a_en;
  logic [2:0]  a_mode;
  logic [3:0]  a_sin_f, a_sin_b;
  logic [15:0] a_pdata_in, a_pdata_out;
  logic [3:0]  a_sout_f, a_sout_b;
  logic [2:0]  a_count;
  logic        a_full;

  // DEPTH=1 instance signals
  logic        b_clear, b_en;
  logic [2:0]  b_mode;
  logic [3:0]  b_sin_f, b_sin_b;
  logic [3:0]  b_pdata_in, b_pdata_out;
  logic [3:0]  b_sout_f, b_sout_b;
  logic [0:0]  b_count;
  logic        b_full;

  universal_shift_reg #(.WIDTH(4), .DEPTH(4)) dut_a (
    .clock(clock), .clear(a_clear), .en(a_en), .mode(a_mode),
    .sin_f(a_sin_f), .sin_b(a_sin_b), .pdata_in(a_pdata_in),
    .pdata_out(a_pdata_out), .sout_f(a_sout_f), .sout_b(a_sout_b),
    .count(a_count), .full(a_full)
  );

  universal_shift_reg #(.WIDTH(4), .DEPTH(1)) dut_b (
    .clock(clock), .clear(b_clear), .en(b_en), .mode(b_mode),
    .sin_f(b_sin_f), .sin_b(b_sin_b), .pdata_in(b_pdata_in),
    .pdata_out(b_pdata_out), .sout_f(b_sout_f), .sout_b(b_sout_b),
    .count(b_count), .full(b_full)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive instance A inputs, then wait one rising edge and settle 1 time unit.
  task automatic step_a(input logic clr, input logic e, input logic [2:0] md,
                        input logic [3:0] sf, input logic [3:0] sb, input logic [15:0] pd);
    a_clear = clr; a_en = e; a_mode = md; a_sin_f = sf; a_sin_b = sb; a_pdata_in = pd;
    @(posedge clock); #1;
  endtask

  task automatic step_b(input logic clr, input logic e, input logic [2:0] md,
                        input logic [3:0] sf, input logic [3:0] sb);
    b_clear = clr; b_en = e; b_mode = md; b_sin_f = sf; b_sin_b = sb; b_pdata_in = 4'hD;
    @(posedge clock); #1;
  endtask

  task automatic check_a(input string tag, input logic [15:0] pd, input logic [2:0] cnt, input logic fl);
    check({tag, " pdata_out"}, a_pdata_out, pd);
    check({tag, " sout_f"},    a_sout_f,    pd[15:12]);
    check({tag, " sout_b"},    a_sout_b,    pd[3:0]);
    check({tag, " count"},     a_count,     cnt);
    check({tag, " full"},      a_full,      fl);
  endtask

  task automatic check_b(input string tag, input logic [3:0] d, input logic cnt);
    check({tag, " pdata_out"}, b_pdata_out, d);
    check({tag, " sout_f"},    b_sout_f,    d);
    check({tag, " sout_b"},    b_sout_b,    d);
    check({tag, " count"},     b_count,     cnt);
    check({tag, " full"},      b_full,      cnt);
  endtask

  initial begin
    b_clear = 1'b1; b_en = 1'b0; b_mode = HOLD; b_sin_f = '0; b_sin_b = '0; b_pdata_in = '0;

    // Reset state
    step_a(1, 0, HOLD, 4'h0, 4'h0, 16'h0);
    check_a("reset", 16'h0000, 3'd0, 1'b0);

    // Serial fill: 1,2,3,4 forward; sin_f reaches sout_f after exactly 4 edges
    step_a(0, 1, SHF, 4'h1, 4'h0, 16'h0);
    step_a(0, 1, SHF, 4'h2, 4'h0, 16'h0);
    step_a(0, 1, SHF, 4'h3, 4'h0, 16'h0);
    check_a("fill3", 16'h0123, 3'd3, 1'b0);
    step_a(0, 1, SHF, 4'h4, 4'h0, 16'h0);
    check_a("fill4", 16'h1234, 3'd4, 1'b1);
    step_a(0, 1, SHF, 4'h5, 4'h0, 16'h0);
    step_a(0, 1, SHF, 4'h6, 4'h0, 16'h0);
    check_a("fill_sat", 16'h3456, 3'd4, 1'b1);

    // Clear beats load; then load from empty sets count to full
    step_a(1, 1, LOAD, 4'h0, 4'h0, 16'hA5C3);
    check_a("clear_over_load", 16'h0000, 3'd0, 1'b0);
    step_a(0, 1, LOAD, 4'h0, 4'h0, 16'hA5C3);
    check_a("load", 16'hA5C3, 3'd4, 1'b1);
    step_a(0, 1, ROTF, 4'h9, 4'h9, 16'h0);
    check_a("rotf", 16'h5C3A, 3'd4, 1'b1);
    step_a(0, 1, ROTB, 4'h9, 4'h9, 16'h0);
    check_a("rotb", 16'hA5C3, 3'd4, 1'b1);

    // Rotate leaves a partial count alone
    step_a(1, 0, HOLD, 4'h0, 4'h0, 16'h0);
    step_a(0, 1, SHF, 4'h7, 4'h0, 16'h0);
    check_a("partial", 16'h0007, 3'd1, 1'b0);
    step_a(0, 1, ROTF, 4'h0, 4'h0, 16'h0);
    check_a("rotf_partial", 16'h0070, 3'd1, 1'b0);
    step_a(0, 1, ROTB, 4'h0, 4'h0, 16'h0);
    step_a(0, 1, ROTB, 4'h0, 4'h0, 16'h0);
    check_a("rotb_wrap", 16'h7000, 3'd1, 1'b0);

    // Backward shift
    step_a(0, 1, LOAD, 4'h0, 4'h0, 16'h1234);
    step_a(0, 1, SHB, 4'h0, 4'hF, 16'h0);
    check_a("shb", 16'hF123, 3'd4, 1'b1);

    // en=0 holds under every mode; reserved modes and hold mode hold with en=1
    for (int m = 0; m < 8; m++) begin
      for (int k = 0; k < 3; k++) step_a(0, 0, 3'(m), 4'hE, 4'hE, 16'hFFFF);
      check_a($sformatf("en0_mode%0d", m), 16'hF123, 3'd4, 1'b1);
    end
    step_a(0, 1, 3'b110, 4'hE, 4'hE, 16'hFFFF);
    check_a("mode110", 16'hF123, 3'd4, 1'b1);
    step_a(0, 1, 3'b111, 4'hE, 4'hE, 16'hFFFF);
    check_a("mode111", 16'hF123, 3'd4, 1'b1);
    step_a(0, 1, HOLD, 4'hE, 4'hE, 16'hFFFF);
    check_a("mode000", 16'hF123, 3'd4, 1'b1);

    // Mid-operation clear with en=1, then clear with en=0
    step_a(1, 0, HOLD, 4'h0, 4'h0, 16'h0);
    step_a(0, 1, SHF, 4'h8, 4'h0, 16'h0);
    step_a(0, 1, SHF, 4'h9, 4'h0, 16'h0);
    check_a("pre_clear", 16'h0089, 3'd2, 1'b0);
    step_a(1, 1, SHF, 4'hB, 4'h0, 16'h0);
    check_a("clear_en1", 16'h0000, 3'd0, 1'b0);
    step_a(0, 1, SHF, 4'hA, 4'h0, 16'h0);
    check_a("post_clear", 16'h000A, 3'd1, 1'b0);
    step_a(1, 0, SHF, 4'hB, 4'h0, 16'h0);
    check_a("clear_en0", 16'h0000, 3'd0, 1'b0);
    step_a(0, 0, HOLD, 4'h0, 4'h0, 16'h0);

    // DEPTH=1 instance
    step_b(1, 0, HOLD, 4'h0, 4'h0);
    check_b("d1_reset", 4'h0, 1'b0);
    step_b(0, 1, SHF, 4'h9, 4'h3);
    check_b("d1_shf", 4'h9, 1'b1);
    step_b(0, 1, ROTF, 4'h1, 4'h2);
    check_b("d1_rotf", 4'h9, 1'b1);
    step_b(0, 1, ROTB, 4'h1, 4'h2);
    check_b("d1_rotb", 4'h9, 1'b1);
    step_b(0, 1, SHB, 4'h1, 4'h6);
    check_b("d1_shb", 4'h6, 1'b1);
    step_b(0, 1, LOAD, 4'h1, 4'h2);
    check_b("d1_load", 4'hD, 1'b1);
    step_b(1, 1, SHF, 4'h5, 4'h5);
    check_b("d1_clear", 4'h0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
